// File: rtl/rs_pkg.sv
// Shared constants and state encoding for the reservation-station issue stage.
package rs_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 144;
    localparam int unsigned DEF_OPER_WIDTH = 32;
    localparam int unsigned DEF_TAG_WIDTH  = 32;

    // Branch tag field inside an RS element
    localparam int unsigned BR_TAG_HI = 143;
    localparam int unsigned BR_TAG_LO = 112;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } issueState_t;

endpackage

// File: rtl/rs_issue_unit_if.sv
// RS head, CDB, branch and FU handshake signals of the issue stage.
interface rs_issue_unit_if
    import rs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned OPER_WIDTH = DEF_OPER_WIDTH,
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH
) ();

    logic [DATA_WIDTH-1:0] RSHeadElement;
    logic                  RSHeadFlagA;
    logic                  RSHeadFlagB;
    logic [OPER_WIDTH-1:0] RSHeadDataA;
    logic [OPER_WIDTH-1:0] RSHeadDataB;
    logic                  RSBufEmpty;
    logic                  RSPop;
    logic                  CDBValid;
    logic [TAG_WIDTH-1:0]  CDBTag;
    logic [OPER_WIDTH-1:0] CDBData;
    logic                  Branch;
    logic [TAG_WIDTH-1:0]  BranchTag;
    logic                  FUValid;
    logic                  FUReady;
    logic [DATA_WIDTH-1:0] FUElement;
    logic [OPER_WIDTH-1:0] FUOpA;
    logic [OPER_WIDTH-1:0] FUOpB;
    logic                  IssueBusy;

    // Issue unit side
    modport master (
        input  RSHeadElement, RSHeadFlagA, RSHeadFlagB, RSHeadDataA, RSHeadDataB, RSBufEmpty,
        input  CDBValid, CDBTag, CDBData, Branch, BranchTag, FUReady,
        output RSPop, FUValid, FUElement, FUOpA, FUOpB, IssueBusy
    );

    // Environment side (RS, CDB, branch unit, FU)
    modport slave (
        output RSHeadElement, RSHeadFlagA, RSHeadFlagB, RSHeadDataA, RSHeadDataB, RSBufEmpty,
        output CDBValid, CDBTag, CDBData, Branch, BranchTag, FUReady,
        input  RSPop, FUValid, FUElement, FUOpA, FUOpB, IssueBusy
    );

endinterface

// File: rtl/operand_snoop.sv
// One source operand: ready flag plus value (or producer tag while pending).
module operand_snoop #(
    parameter int unsigned OPER_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  loadFlag,
    input  logic [OPER_WIDTH-1:0] loadData,
    input  logic                  snoopEn,
    input  logic                  clear,
    input  logic                  cdbValid,
    input  logic [TAG_WIDTH-1:0]  cdbTag,
    input  logic [OPER_WIDTH-1:0] cdbData,
    output logic                  ready,
    output logic [OPER_WIDTH-1:0] value,
    output logic                  readyNext_c
);

    logic [OPER_WIDTH-1:0] valueNext;
    logic                  loadHit;
    logic                  snoopHit;

    assign loadHit  = cdbValid && (cdbTag == TAG_WIDTH'(loadData));
    assign snoopHit = cdbValid && (cdbTag == TAG_WIDTH'(value));

    // Load with same-cycle CDB bypass, otherwise snoop while pending
    always_comb begin
        readyNext_c = ready;
        valueNext   = value;
        if (clear) begin
            readyNext_c = 1'b0;
        end else if (load) begin
            if (loadFlag) begin
                readyNext_c = 1'b1;
                valueNext   = loadData;
            end else if (loadHit) begin
                readyNext_c = 1'b1;
                valueNext   = cdbData;
            end else begin
                readyNext_c = 1'b0;
                valueNext   = loadData;
            end
        end else if (snoopEn && !ready && snoopHit) begin
            readyNext_c = 1'b1;
            valueNext   = cdbData;
        end
    end

    // Operand state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            value <= '0;
        end else begin
            ready <= readyNext_c;
            value <= valueNext;
        end
    end

endmodule

// File: rtl/rs_issue_unit.sv
// Issue stage: holds one RS element, resolves pending operands off the CDB, issues to the FU.
module rs_issue_unit
    import rs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned OPER_WIDTH = DEF_OPER_WIDTH,
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic            CLK,
    input  logic            Reset,
    rs_issue_unit_if.master bus
);

    issueState_t           state;
    issueState_t           stateNext;
    logic                  fuValidQ;
    logic [DATA_WIDTH-1:0] elementQ;
    logic                  transfer;
    logic                  slotFree;
    logic                  pop;
    logic                  flush;
    logic                  snoopEn;
    logic                  clearOps;
    logic                  readyA;
    logic                  readyB;
    logic                  readyANext;
    logic                  readyBNext;
    logic [OPER_WIDTH-1:0] opA;
    logic [OPER_WIDTH-1:0] opB;

    assign transfer = fuValidQ & bus.FUReady;
    assign slotFree = (state == IDLE) | transfer;
    // Any branch blocks the pop: the head itself may be squashed this cycle
    assign pop      = slotFree & ~bus.RSBufEmpty & ~bus.Branch & ~Reset;
    assign flush    = bus.Branch & (state != IDLE)
                    & (elementQ[BR_TAG_HI:BR_TAG_LO] == bus.BranchTag);
    assign snoopEn  = (state == WAIT) & ~flush;
    // Pop and flush are mutually exclusive since Branch suppresses pop
    assign clearOps = flush | (transfer & ~pop);

    operand_snoop #(.OPER_WIDTH(OPER_WIDTH), .TAG_WIDTH(TAG_WIDTH)) snoopA (
        .clk(CLK), .reset(Reset), .load(pop), .loadFlag(bus.RSHeadFlagA),
        .loadData(bus.RSHeadDataA), .snoopEn(snoopEn), .clear(clearOps),
        .cdbValid(bus.CDBValid), .cdbTag(bus.CDBTag), .cdbData(bus.CDBData),
        .ready(readyA), .value(opA), .readyNext_c(readyANext)
    );

    operand_snoop #(.OPER_WIDTH(OPER_WIDTH), .TAG_WIDTH(TAG_WIDTH)) snoopB (
        .clk(CLK), .reset(Reset), .load(pop), .loadFlag(bus.RSHeadFlagB),
        .loadData(bus.RSHeadDataB), .snoopEn(snoopEn), .clear(clearOps),
        .cdbValid(bus.CDBValid), .cdbTag(bus.CDBTag), .cdbData(bus.CDBData),
        .ready(readyB), .value(opB), .readyNext_c(readyBNext)
    );

    // Next-state: capture, operand wait, issue with back-to-back refill, flush
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (pop) stateNext = (readyANext && readyBNext) ? ISSUE : WAIT;
            end
            WAIT: begin
                if (flush)                          stateNext = IDLE;
                else if (readyANext && readyBNext)  stateNext = ISSUE;
            end
            ISSUE: begin
                if (transfer) begin
                    if (pop) stateNext = (readyANext && readyBNext) ? ISSUE : WAIT;
                    else     stateNext = IDLE;
                end else if (flush) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and issue-valid registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            fuValidQ <= 1'b0;
        end else begin
            state    <= stateNext;
            fuValidQ <= (stateNext == ISSUE);
        end
    end

    // Held element register
    always_ff @(posedge CLK) begin
        if (Reset)    elementQ <= '0;
        else if (pop) elementQ <= bus.RSHeadElement;
    end

    assign bus.RSPop     = pop;
    assign bus.FUValid   = fuValidQ;
    assign bus.FUElement = elementQ;
    assign bus.FUOpA     = opA;
    assign bus.FUOpB     = opB;
    assign bus.IssueBusy = (state != IDLE);

    logic unusedReady;
    assign unusedReady = readyA ^ readyB;

endmodule

// File: tb/tb_rs_issue_unit.sv
// Bench for rs_issue_unit: directed plan steps then randomized traffic vs a slot-level model.
module tb_rs_issue_unit;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rs_issue_unit_if bus ();

    rs_issue_unit dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Model: one held element with per-operand ready/value
    logic         mValid;
    logic [143:0] mElem;
    logic         mARdy, mBRdy;
    logic [31:0]  mAVal, mBVal;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic modelIssuing();
        return mValid && mARdy && mBRdy;
    endfunction

    function automatic logic expPop();
        logic xfer;
        xfer = modelIssuing() && bus.FUReady;
        return (!mValid || xfer) && !bus.RSBufEmpty && !bus.Branch && !rst;
    endfunction

    // Apply one clock edge worth of behaviour using the current inputs
    task automatic modelEdge();
        logic p, xfer, fl;
        p    = expPop();
        xfer = modelIssuing() && bus.FUReady;
        fl   = bus.Branch && mValid && (mElem[143:112] == bus.BranchTag);
        if (rst) begin
            mValid = 0; mElem = '0; mARdy = 0; mBRdy = 0; mAVal = '0; mBVal = '0;
        end else if (p) begin
            mValid = 1;
            mElem  = bus.RSHeadElement;
            mARdy  = bus.RSHeadFlagA || (bus.CDBValid && bus.CDBTag == bus.RSHeadDataA);
            mAVal  = bus.RSHeadFlagA ? bus.RSHeadDataA : (mARdy ? bus.CDBData : bus.RSHeadDataA);
            mBRdy  = bus.RSHeadFlagB || (bus.CDBValid && bus.CDBTag == bus.RSHeadDataB);
            mBVal  = bus.RSHeadFlagB ? bus.RSHeadDataB : (mBRdy ? bus.CDBData : bus.RSHeadDataB);
        end else if (xfer || fl) begin
            mValid = 0;
        end else if (mValid) begin
            if (!mARdy && bus.CDBValid && bus.CDBTag == mAVal) begin mARdy = 1; mAVal = bus.CDBData; end
            if (!mBRdy && bus.CDBValid && bus.CDBTag == mBVal) begin mBRdy = 1; mBVal = bus.CDBData; end
        end
    endtask

    // One clock: check RSPop before the edge, outputs after it
    task automatic cycle();
        #1;
        chk("RSPop", 144'(bus.RSPop), 144'(expPop()));
        modelEdge();
        @(posedge clk);
        #1;
        chk("FUValid", 144'(bus.FUValid), 144'(modelIssuing()));
        chk("IssueBusy", 144'(bus.IssueBusy), 144'(mValid));
        if (modelIssuing()) begin
            chk("FUElement", bus.FUElement, mElem);
            chk("FUOpA", 144'(bus.FUOpA), 144'(mAVal));
            chk("FUOpB", 144'(bus.FUOpB), 144'(mBVal));
        end
    endtask

    function automatic logic [143:0] mkElem(input logic [31:0] brTag);
        return {brTag, 32'($urandom()), 32'($urandom()), 32'($urandom()), 16'($urandom())};
    endfunction

    task automatic setHead(input logic [31:0] brTag, input logic fa, input logic [31:0] da,
                           input logic fb, input logic [31:0] db, input logic empty);
        bus.RSHeadElement = mkElem(brTag);
        bus.RSHeadFlagA = fa; bus.RSHeadDataA = da;
        bus.RSHeadFlagB = fb; bus.RSHeadDataB = db;
        bus.RSBufEmpty  = empty;
    endtask

    task automatic setCdb(input logic v, input logic [31:0] t, input logic [31:0] d);
        bus.CDBValid = v; bus.CDBTag = t; bus.CDBData = d;
    endtask

    logic [143:0] heldElem;
    logic [31:0]  heldA, heldB;

    initial begin
        mValid = 0; mElem = '0; mARdy = 0; mBRdy = 0; mAVal = '0; mBVal = '0;
        rst = 1;
        setHead(32'h0, 1, 32'h0, 1, 32'h0, 1);
        setCdb(0, 32'h0, 32'h0);
        bus.Branch = 0; bus.BranchTag = '0; bus.FUReady = 1;

        // Reset state
        cycle(); cycle();
        chk("rst_FUElement", bus.FUElement, 144'h0);
        chk("rst_FUOpA", 144'(bus.FUOpA), 144'h0);
        chk("rst_FUOpB", 144'(bus.FUOpB), 144'h0);
        rst = 0;
        cycle();

        // Both operands ready at pop
        setHead(32'h1, 1, 32'h11, 1, 32'h22, 0);
        cycle();
        chk("ready_FUValid", 144'(bus.FUValid), 144'h1);
        chk("ready_opA", 144'(bus.FUOpA), 144'h11);
        chk("ready_opB", 144'(bus.FUOpB), 144'h22);
        bus.RSBufEmpty = 1;
        cycle();
        chk("ready_idle", 144'(bus.IssueBusy), 144'h0);

        // Operand A pending on tag 7, resolved three cycles later
        setHead(32'h1, 0, 32'h7, 1, 32'h33, 0);
        cycle();
        bus.RSBufEmpty = 1;
        setCdb(1, 32'h6, 32'h5555);
        cycle();
        setCdb(0, 32'h7, 32'h1234);
        cycle();
        chk("wait_FUValid", 144'(bus.FUValid), 144'h0);
        setCdb(1, 32'h7, 32'hABCD);
        cycle();
        chk("wait_opA", 144'(bus.FUOpA), 144'hABCD);
        setCdb(0, 32'h0, 32'h0);
        cycle();

        // Both pending on tag 5, one broadcast
        setHead(32'h2, 0, 32'h5, 0, 32'h5, 0);
        cycle();
        bus.RSBufEmpty = 1;
        setCdb(1, 32'h5, 32'h99);
        cycle();
        chk("dual_opA", 144'(bus.FUOpA), 144'h99);
        chk("dual_opB", 144'(bus.FUOpB), 144'h99);
        setCdb(0, 32'h0, 32'h0);
        cycle();

        // Stalled FU: outputs frozen, no pop, CDB ignored; then back-to-back refill
        bus.FUReady = 0;
        setHead(32'h2, 1, 32'h44, 1, 32'h55, 0);
        cycle();
        heldElem = bus.FUElement; heldA = bus.FUOpA; heldB = bus.FUOpB;
        for (int i = 0; i < 4; i++) begin
            setHead(32'h2, 1, 32'h66, 0, 32'h55, 0);
            setCdb(1, 32'h44, 32'hDEAD);
            cycle();
            chk("stall_elem", bus.FUElement, heldElem);
            chk("stall_opA", 144'(bus.FUOpA), 144'(heldA));
            chk("stall_opB", 144'(bus.FUOpB), 144'(heldB));
        end
        setCdb(0, 32'h0, 32'h0);
        bus.FUReady = 1;
        setHead(32'h2, 1, 32'h77, 1, 32'h88, 0);
        #1;
        chk("b2b_pop", 144'(bus.RSPop), 144'h1);
        cycle();
        chk("b2b_opA", 144'(bus.FUOpA), 144'h77);
        bus.RSBufEmpty = 1;
        cycle();

        // Flush: non-matching tag keeps the entry, matching tag drops it
        setHead(32'h3, 0, 32'h6, 1, 32'h12, 0);
        cycle();
        bus.RSBufEmpty = 0;
        bus.Branch = 1; bus.BranchTag = 32'h4;
        cycle();
        chk("noflush_busy", 144'(bus.IssueBusy), 144'h1);
        bus.BranchTag = 32'h3;
        #1;
        chk("flush_nopop", 144'(bus.RSPop), 144'h0);
        cycle();
        chk("flush_idle", 144'(bus.IssueBusy), 144'h0);
        chk("flush_novalid", 144'(bus.FUValid), 144'h0);
        bus.Branch = 0; bus.RSBufEmpty = 1;
        cycle();

        // Reset while issuing
        bus.FUReady = 0;
        setHead(32'h1, 1, 32'h9, 1, 32'hA, 0);
        cycle();
        rst = 1;
        cycle();
        chk("rstmid_valid", 144'(bus.FUValid), 144'h0);
        chk("rstmid_busy", 144'(bus.IssueBusy), 144'h0);
        rst = 0;
        bus.FUReady = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            setHead(32'($urandom_range(7)),
                    1'($urandom_range(1)), 32'($urandom_range(7)),
                    1'($urandom_range(1)), 32'($urandom_range(7)),
                    ($urandom_range(3) == 0));
            if (bus.RSHeadFlagA) bus.RSHeadDataA = $urandom();
            if (bus.RSHeadFlagB) bus.RSHeadDataB = $urandom();
            setCdb(1'($urandom_range(1)), 32'($urandom_range(7)), $urandom());
            bus.Branch    = ($urandom_range(7) == 0);
            bus.BranchTag = 32'($urandom_range(7));
            bus.FUReady   = ($urandom_range(9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
